// File: rtl/fetch_stage.sv
// fetch_stage: program counter, combinational instruction-memory addressing and
// the IF/ID pipeline register. Handles stall, branch/jump redirect and a halt word.
module fetch_stage #(
    parameter int          ADDR_BITS = 11,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    input  logic                 jump,
    input  logic [31:0]          jump_target,
    input  logic [31:0]          mem_instr,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          pc,
    output logic [31:0]          if_id_instr,
    output logic [31:0]          if_id_pc4,
    output logic                 if_id_valid,
    output logic                 halted,
    output logic [31:0]          fetch_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus4;

    // PC+4 wraps naturally in 32 bits.
    assign pc_plus4 = pc_q + 32'd4;

    // Next-state and next-register values, in redirect > stall > halt > normal order.
    always_comb begin
        // NOTE: every target gets a hold value first, so no path can infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        count_d = count_q;

        if (branch_taken) begin
            // The branch is older than a jump in ID, so it wins.
            pc_d    = {branch_target[31:2], 2'b00};
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (jump) begin
            pc_d    = {jump_target[31:2], 2'b00};
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (stall) begin
            // Everything holds on the defaults.
        end else if (state_q == HALT) begin
            // PC frozen; keep inserting bubbles until a redirect or reset.
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (mem_instr == HALT_WORD) begin
            // The halt word is neither forwarded nor counted; PC stays on it.
            state_d = HALT;
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else begin
            pc_d    = pc_plus4;
            instr_d = mem_instr;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    // State and pipeline registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Word address into instr_mem; upper PC bits alias by design.
    assign mem_addr    = pc_q[ADDR_BITS+1:2];
    assign pc          = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign halted      = (state_q == HALT);
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a behavioural asynchronous instruction memory.
module tb_fetch_stage;

    localparam int          ADDR_BITS = 11;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 stall;
    logic                 branch_taken;
    logic [31:0]          branch_target;
    logic                 jump;
    logic [31:0]          jump_target;
    logic [31:0]          mem_instr;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [31:0]          pc;
    logic [31:0]          if_id_instr;
    logic [31:0]          if_id_pc4;
    logic                 if_id_valid;
    logic                 halted;
    logic [31:0]          fetch_count;

    logic [31:0] mem [0:(1<<ADDR_BITS)-1];

    int total = 0;
    int bad   = 0;

    fetch_stage #(
        .ADDR_BITS(ADDR_BITS),
        .RESET_PC (32'h0000_0000),
        .HALT_WORD(HALT_WORD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .mem_instr    (mem_instr),
        .mem_addr     (mem_addr),
        .pc           (pc),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    assign mem_instr = mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                              input logic valid, input logic [31:0] exp_pc, input logic [31:0] cnt);
        check({tag, ".instr"}, if_id_instr, instr);
        check({tag, ".pc4"},   if_id_pc4, pc4);
        check({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, valid});
        check({tag, ".pc"},    pc, exp_pc);
        check({tag, ".count"}, fetch_count, cnt);
    endtask

    task automatic check_reset(input string tag);
        check_ifid(tag, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        check({tag, ".halted"}, {31'b0, halted}, 32'h0);
        check({tag, ".addr"}, {21'b0, mem_addr}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_BITS); i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        mem[3] = 32'h44;
        mem[5] = HALT_WORD;

        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0;
        step();
        check_reset("reset");

        // Sequential fetch of words 0 and 1.
        rst = 1'b0;
        step(); check_ifid("f0", 32'h11, 32'd4, 1'b1, 32'd4, 32'd1);
        step(); check_ifid("f1", 32'h22, 32'd8, 1'b1, 32'd8, 32'd2);

        // Stall three edges: nothing moves.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); check_ifid("stall", 32'h22, 32'd8, 1'b1, 32'd8, 32'd2);
        end
        stall = 1'b0;
        step(); check_ifid("f2", 32'h33, 32'd12, 1'b1, 32'd12, 32'd3);
        step(); check_ifid("f3", 32'h44, 32'd16, 1'b1, 32'd16, 32'd4);
        step(); check_ifid("f4", 32'hA000_0004, 32'd20, 1'b1, 32'd20, 32'd5);

        // Word 5 is the halt word.
        step(); check_ifid("halt", 32'h0, 32'h0, 1'b0, 32'h14, 32'd5);
        check("halt.halted", {31'b0, halted}, 32'h1);
        for (int k = 0; k < 10; k++) begin
            step(); check_ifid("halted", 32'h0, 32'h0, 1'b0, 32'h14, 32'd5);
            check("halted.flag", {31'b0, halted}, 32'h1);
        end

        // Branch out of HALT to 0.
        branch_taken = 1'b1; branch_target = 32'h0;
        step(); check_ifid("unhalt", 32'h0, 32'h0, 1'b0, 32'h0, 32'd5);
        check("unhalt.halted", {31'b0, halted}, 32'h0);
        branch_taken = 1'b0;
        step(); check_ifid("resume", 32'h11, 32'd4, 1'b1, 32'd4, 32'd6);

        // Jump overrides stall.
        jump = 1'b1; jump_target = 32'h40; stall = 1'b1;
        step(); check_ifid("jump", 32'h0, 32'h0, 1'b0, 32'h40, 32'd6);
        jump = 1'b0; stall = 1'b0;
        step(); check_ifid("jtgt", 32'hA000_0010, 32'h44, 1'b1, 32'h44, 32'd7);

        // Branch beats jump in the same cycle.
        branch_taken = 1'b1; branch_target = 32'h80; jump = 1'b1; jump_target = 32'h40;
        step(); check_ifid("bj", 32'h0, 32'h0, 1'b0, 32'h80, 32'd7);
        jump = 1'b0;

        // Unaligned target is forced to a word boundary.
        branch_target = 32'h103;
        step(); check_ifid("align", 32'h0, 32'h0, 1'b0, 32'h100, 32'd7);
        check("align.addr", {21'b0, mem_addr}, 32'h40);
        branch_taken = 1'b0;
        step(); check_ifid("atgt", 32'hA000_0040, 32'h104, 1'b1, 32'h104, 32'd8);

        // PC wrap from the top of the address space.
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        step(); check("wrap.pc", pc, 32'hFFFF_FFFC);
        check("wrap.addr", {21'b0, mem_addr}, 32'h7FF);
        branch_taken = 1'b0;
        step(); check_ifid("wrap", 32'hA000_07FF, 32'h0, 1'b1, 32'h0, 32'd9);

        // Reset during stall restores everything.
        stall = 1'b1; rst = 1'b1;
        step(); check_reset("rst_stall");
        stall = 1'b0; rst = 1'b0;
        step(); check_ifid("post_rst", 32'h11, 32'd4, 1'b1, 32'd4, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined CPU. It holds the program counter and addresses `instr_mem` combinationally through `mem_addr`. It latches the returned word into the IF/ID pipeline register and handles stall, branch/jump redirect and a halt word. It sits directly upstream of `instr_mem` and feeds the decode stage.

## Interface
- `ADDR_BITS`, 11: word-address width of `instr_mem`.
- `RESET_PC`, 32'h0000_0000: byte address fetched first after reset.
- `HALT_WORD`, 32'hFFFF_FFFF: instruction encoding that stops fetch.
- `clk`  in  1: clock; all state updates on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: hold PC and IF/ID (load-use hazard from ID).
- `branch_taken`  in  1: EX-stage branch resolved taken.
- `branch_target`  in  32: byte target for `branch_taken`.
- `jump`  in  1: ID-stage jump.
- `jump_target`  in  32: byte target for `jump`.
- `mem_instr`  in  32: word returned by `instr_mem` for `mem_addr`.
- `mem_addr`  out  ADDR_BITS: `pc[ADDR_BITS+1:2]`, combinational.
- `pc`  out  32: current fetch PC.
- `if_id_instr`  out  32: latched instruction.
- `if_id_pc4`  out  32: latched PC+4.
- `if_id_valid`  out  1: IF/ID holds a real instruction.
- `halted`  out  1: fetch FSM is in HALT.
- `fetch_count`  out  32: number of valid instructions latched into IF/ID.

## Operation
- Reset values: `pc`=RESET_PC, `if_id_instr`=0 (nop), `if_id_pc4`=0, `if_id_valid`=0, `halted`=0, `fetch_count`=0, FSM=RUN.
- Targets are word-aligned by forcing bits [1:0] to 00. The PC is 32 bits and wraps mod 2^32. `mem_addr` truncation aliases addresses beyond 2^ADDR_BITS words; this is intended.
- Per-cycle priority, highest first: `rst` > `branch_taken` > `jump` > `stall` > halt detect > normal.
- `branch_taken`: `pc` <= branch_target & ~3 and IF/ID <= bubble (instr 0, valid 0). This overrides `stall` and `jump` because the branch is the older instruction. In HALT, the FSM returns to RUN.
- `jump`, with no branch: `pc` <= jump_target & ~3, IF/ID <= bubble, FSM -> RUN. It overrides `stall`.
- `stall` only: `pc`, IF/ID and FSM hold. `fetch_count` holds.
- RUN, normal:
  - If `mem_instr` != HALT_WORD: `pc` <= pc+4, `if_id_instr` <= mem_instr, `if_id_pc4` <= pc+4, `if_id_valid` <= 1, `fetch_count` += 1 (wraps).
  - If `mem_instr` == HALT_WORD: FSM -> HALT, `pc` holds at the halt word's address, and IF/ID <= bubble. The halt word is not forwarded and not counted.
- HALT: `pc` frozen, IF/ID bubble every cycle, `halted`=1. Leave HALT only on `rst`, `branch_taken` or `jump`, because the halt may be speculative.
- A bubble never increments `fetch_count`.

## Timing
- `mem_addr` follows `pc` combinationally. `instr_mem` read is asynchronous, so instruction fetch latency is one cycle from PC to IF/ID.
- First edge after `rst` deasserts: IF/ID gets mem[RESET_PC>>2] with `if_id_pc4`=RESET_PC+4.
- A redirect asserted in cycle N puts `pc`=target after edge N. The target instruction is valid in IF/ID after edge N+1, giving a one-cycle bubble.
- `halted` rises at the edge on which HALT_WORD is seen on `mem_instr`. It falls at the edge of a redirect.
- `rst` mid-operation, including in HALT or during `stall`, restores all reset values at that edge.
- `stall` held k cycles: outputs are unchanged for exactly k edges.

## Test plan
- Reset with RESET_PC=0, memory words 0..3 = 0x11,0x22,0x33,0x44 -> after edges 1..4, IF/ID = (0x11,pc4 4), (0x22,8), (0x33,12), (0x44,16); `fetch_count`=4.
- `stall` for 3 cycles while IF/ID=(0x22,8) -> IF/ID, `pc`=8 and `fetch_count` unchanged for 3 edges, then (0x33,12).
- `jump`=1 with jump_target=0x40 together with `stall`=1 -> `pc`=0x40, `if_id_valid`=0. The next edge latches mem[16] with pc4=0x44.
- `branch_taken` target 0x80 and `jump` target 0x40 in the same cycle -> `pc`=0x80, bubble.
- Word 5 = HALT_WORD -> `halted`=1 with `pc`=0x14 frozen, `if_id_valid`=0 for 10 cycles, `fetch_count` frozen. Then `branch_taken` to 0x0 -> `halted`=0, `pc`=0, fetch resumes.
- `branch_target`=0x103 -> `pc`=0x100, `mem_addr`=0x40. `pc`=0xFFFF_FFFC with normal fetch -> `pc` wraps to 0.
